// File: rtl/rv32i_mc_core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, funct3 codes, FSM states, ALU helper.
// No logic of its own.
package rv32i_mc_core_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;

  localparam logic [2:0] F3_SB   = 3'd0;
  localparam logic [2:0] F3_SH   = 3'd1;
  localparam logic [2:0] F3_SW   = 3'd2;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_TRAP
  } state_t;

  // alt selects SUB for ADD and arithmetic shift for SR
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f3)
      F3_ADD:  r = alt ? (a - b) : (a + b);
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      F3_SLTU: r = {31'd0, a < b};
      F3_XOR:  r = a ^ b;
      F3_SR: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      F3_OR:   r = a | b;
      F3_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// Integer register file: x1..x31, two combinational read ports, one write port, x0 reads zero.
// Latency: reads same cycle, writes visible the cycle after we.
// Backpressure: none; write accepted every cycle it is enabled.
module rv32i_regfile #(
  parameter logic [31:0] STACKADDR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [1:31];

  // x2 starts at STACKADDR unless STACKADDR is the all-ones "not preset" value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (i == 2 && STACKADDR != 32'hFFFF_FFFF) ? STACKADDR : 32'd0;
      end
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/rv32i_mc_core.sv
// Multi-cycle non-pipelined RV32I core with one shared memory port for fetch and data.
// Latency: ALU/branch/jump = fetch + 1 cycle; load/store = fetch + 1 + data transfer.
// Backpressure: each request is held stable until mem_valid && mem_ready; any number of wait states.
module rv32i_mc_core
  import rv32i_mc_core_pkg::*;
#(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter logic [31:0] STACKADDR      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [1:0]  ea_lo;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, alu_b;
  logic        alu_alt;

  logic        illegal, misalign, wb_en, is_load, is_store, taken;
  logic [31:0] ea, next_pc, wb_val, st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_word, ld_val;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'd0};
  assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;
  assign alu_b    = (opcode == OPC_OP) ? rs2_val : imm_i;
  // ADDI has no subtract form, so bit 30 only matters for shifts on OP-IMM
  assign alu_alt  = instr[30] && (opcode == OPC_OP || funct3 == F3_SR);

  rv32i_regfile #(
    .STACKADDR (STACKADDR)
  ) u_regfile (
    .clk    (clk),
    .resetn (resetn),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (rf_we),
    .waddr  (instr[11:7]),
    .wdata  (rf_wdata)
  );

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    wb_en    = 1'b0;
    wb_val   = '0;
    is_load  = 1'b0;
    is_store = 1'b0;
    taken    = 1'b0;
    next_pc  = pc_plus4;
    ea       = rs1_val + imm_i;
    st_wdata = rs2_val;
    st_wstrb = 4'b0000;
    case (opcode)
      OPC_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OPC_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc + imm_u;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_val  = pc_plus4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        illegal = (funct3 != 3'd0);
        wb_en   = 1'b1;
        wb_val  = pc_plus4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  taken = (rs1_val == rs2_val);
          F3_BNE:  taken = (rs1_val != rs2_val);
          F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
          F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
          F3_BLTU: taken = (rs1_val < rs2_val);
          F3_BGEU: taken = (rs1_val >= rs2_val);
          default: illegal = 1'b1;
        endcase
        if (taken) next_pc = pc + imm_b;
      end
      OPC_LOAD: begin
        is_load = 1'b1;
        case (funct3)
          F3_LB, F3_LBU: misalign = 1'b0;
          F3_LH, F3_LHU: misalign = ea[0];
          F3_LW:         misalign = |ea[1:0];
          default:       illegal  = 1'b1;
        endcase
      end
      OPC_STORE: begin
        is_store = 1'b1;
        ea       = rs1_val + imm_s;
        case (funct3)
          F3_SB: begin
            st_wdata = {4{rs2_val[7:0]}};
            st_wstrb = 4'b0001 << ea[1:0];
          end
          F3_SH: begin
            st_wdata = {2{rs2_val[15:0]}};
            st_wstrb = 4'b0011 << ea[1:0];
            misalign = ea[0];
          end
          F3_SW: begin
            st_wstrb = 4'b1111;
            misalign = |ea[1:0];
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        wb_en  = 1'b1;
        wb_val = alu_op(funct3, alu_alt, rs1_val, alu_b);
        if (funct3 == F3_SLL) illegal = (funct7 != 7'h00);
        if (funct3 == F3_SR)  illegal = (funct7 != 7'h00 && funct7 != 7'h20);
      end
      OPC_OP: begin
        wb_en   = 1'b1;
        wb_val  = alu_op(funct3, alu_alt, rs1_val, alu_b);
        illegal = !(funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == F3_ADD || funct3 == F3_SR)));
      end
      OPC_MISC_MEM: illegal = (funct3 != 3'd0);
      OPC_SYSTEM:   illegal = 1'b1;
      default:      illegal = 1'b1;
    endcase
    // PC is always word aligned, so only a jump or taken branch can set bit 1
    if (next_pc[1]) misalign = 1'b1;
  end

  assign ld_word = mem_rdata >> {ea_lo, 3'b000};

  always_comb begin
    case (funct3)
      F3_LB:   ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
      F3_LH:   ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
      F3_LBU:  ld_val = {24'd0, ld_word[7:0]};
      F3_LHU:  ld_val = {16'd0, ld_word[15:0]};
      default: ld_val = ld_word;
    endcase
  end

  // loads retire on the data handshake; everything else writes back in EXEC
  assign rf_we = (state == ST_EXEC && wb_en && !illegal && !misalign) ||
                 (state == ST_MEM && mem_valid && mem_ready && mem_wstrb == 4'b0000);
  assign rf_wdata = (state == ST_MEM) ? ld_val : wb_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_FETCH;
      pc        <= PROGADDR_RESET;
      instr     <= '0;
      ea_lo     <= '0;
      trap      <= 1'b0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= pc;
            mem_wstrb <= 4'b0000;
          end else if (mem_ready) begin
            instr     <= mem_rdata;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (illegal || misalign) begin
            trap  <= 1'b1;
            state <= ST_TRAP;
          end else if (is_load || is_store) begin
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_addr  <= {ea[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= st_wstrb;
            ea_lo     <= ea[1:0];
            state     <= ST_MEM;
          end else begin
            // issue the next fetch directly to save a cycle
            pc        <= next_pc;
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= next_pc;
            mem_wstrb <= 4'b0000;
            state     <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            pc        <= pc_plus4;
            state     <= ST_FETCH;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          trap      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: small programs run against a 1 KiB memory model with
// programmable wait states; results are observed on the memory bus and checked against hand values.
module tb_rv32i_mc_core;

  logic        clk;
  logic        resetn;
  logic        trap;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  localparam int PROG_LOOP   = 0;
  localparam int PROG_LOAD   = 1;
  localparam int PROG_BRANCH = 2;
  localparam int PROG_ZERO   = 3;
  localparam int PROG_ECALL  = 4;
  localparam int PROG_MISLW  = 5;

  logic [31:0] mem [0:255];
  txn_t        log_q[$];
  txn_t        wr_q[$];
  txn_t        ref_q[$];
  int          dly;
  int          viol;
  int          checks;
  int          errors;

  rv32i_mc_core u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .trap      (trap),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
    end
  endtask

  // Memory model: decides ready at the negedge, so the DUT samples it on the next posedge.
  initial begin : mem_model
    logic        pend;
    int          wcnt;
    txn_t        cap;
    txn_t        cur;
    pend      = 1'b0;
    wcnt      = 0;
    cap       = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      cur = '{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
      if (resetn && mem_valid) begin
        if (!pend) begin
          pend = 1'b1;
          wcnt = 0;
          cap  = cur;
        end else if (cur != cap) begin
          viol++;
        end
        if (wcnt >= dly) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          log_q.push_back(cur);
          if (mem_wstrb != 4'b0000) wr_q.push_back(cur);
          pend = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic load_prog(input int id);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    case (id)
      PROG_LOOP: begin
        mem[0] = 32'h3FC0_0093;  // addi x1,x0,1020
        mem[1] = 32'h0000_A023;  // sw   x0,0(x1)
        mem[2] = 32'h0000_A103;  // lw   x2,0(x1)
        mem[3] = 32'h0011_0113;  // addi x2,x2,1
        mem[4] = 32'h0020_A023;  // sw   x2,0(x1)
        mem[5] = 32'hFF5F_F06F;  // j    0x8
      end
      PROG_LOAD: begin
        mem[0]  = 32'h0AB0_0193;  // addi x3,x0,0xab
        mem[1]  = 32'h0030_00A3;  // sb   x3,1(x0)
        mem[2]  = 32'h0180_006F;  // j    0x20
        mem[4]  = 32'h80FF_0000;  // data word at 0x10
        mem[8]  = 32'h0120_0203;  // lb   x4,0x12(x0)
        mem[9]  = 32'h0440_2023;  // sw   x4,0x40(x0)
        mem[10] = 32'h0120_4203;  // lbu  x4,0x12(x0)
        mem[11] = 32'h0440_2023;
        mem[12] = 32'h0120_1203;  // lh   x4,0x12(x0)
        mem[13] = 32'h0440_2023;
        mem[14] = 32'h0000_006F;  // j .
      end
      PROG_BRANCH: begin
        mem[0] = 32'hFFF0_0293;  // addi x5,x0,-1
        mem[1] = 32'h0010_0313;  // addi x6,x0,1
        mem[2] = 32'h0062_C463;  // blt  x5,x6,+8  -> 0x10
        mem[4] = 32'h0062_E463;  // bltu x5,x6,+8  (not taken)
        mem[5] = 32'h0210_03E7;  // jalr x7,0x21(x0) -> 0x20
        mem[8] = 32'h0470_2023;  // sw   x7,0x40(x0)
        mem[9] = 32'h0000_006F;  // j .
      end
      PROG_ECALL: mem[0] = 32'h0000_0073;
      PROG_MISLW: mem[0] = 32'h0020_2083;  // lw x1,2(x0)
      default:    mem[0] = 32'h0000_0000;
    endcase
  endtask

  task automatic start(input int id, input int d);
    resetn = 1'b0;
    @(negedge clk);
    load_prog(id);
    dly  = d;
    viol = 0;
    log_q.delete();
    wr_q.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_writes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && wr_q.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, wr_q.size(), n);
  endtask

  task automatic run_trap(input string tag, input int budget);
    for (int i = 0; i < budget && !trap; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, {31'd0, trap}, 32'd1);
  endtask

  function automatic logic [31:0] fetch_after(input logic [31:0] a);
    int k;
    k = -1;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].instr && log_q[i].addr == a) begin k = i; break; end
    if (k >= 0)
      for (int i = k + 1; i < log_q.size(); i++)
        if (log_q[i].instr) return log_q[i].addr;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check_quiet(input string tag);
    int busy;
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_valid) busy++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin : main
    logic [31:0] first_rd;
    int          diffs;
    checks = 0;
    errors = 0;
    dly    = 0;
    viol   = 0;
    resetn = 1'b0;
    #1;
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ctl", {26'd0, mem_instr, trap, mem_wstrb}, 32'd0);

    // counter loop, zero wait states
    start(PROG_LOOP, 0);
    run_writes("loop_wr_cnt", 4, 400);
    chk("loop_f0_addr", log_q[0].addr, 32'h0);
    chk("loop_f0_instr", {31'd0, log_q[0].instr}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("loop_wr%0d_addr", k), wr_q[k].addr, 32'h3FC);
      chk($sformatf("loop_wr%0d_data", k), wr_q[k].wdata, k);
      chk($sformatf("loop_wr%0d_strb", k), {28'd0, wr_q[k].wstrb}, 32'hF);
    end
    first_rd = 32'hFFFF_FFFF;
    for (int i = 0; i < log_q.size(); i++)
      if (!log_q[i].instr && log_q[i].wstrb == 4'b0000) begin first_rd = log_q[i].addr; break; end
    chk("loop_rd_addr", first_rd, 32'h3FC);
    chk("loop_j_target", fetch_after(32'h14), 32'h8);
    ref_q = log_q;

    // same program, five wait states per transfer
    start(PROG_LOOP, 5);
    run_writes("dly_wr_cnt", 4, 2000);
    chk("dly_stable", viol, 0);
    chk("dly_log_len", log_q.size(), ref_q.size());
    diffs = 0;
    for (int i = 0; i < log_q.size() && i < ref_q.size(); i++)
      if (log_q[i] != ref_q[i]) diffs++;
    chk("dly_log_diff", diffs, 0);

    // byte store and sign/zero-extending loads
    start(PROG_LOAD, 0);
    run_writes("ld_wr_cnt", 4, 400);
    chk("sb_addr", wr_q[0].addr, 32'h0);
    chk("sb_data", wr_q[0].wdata, 32'hABAB_ABAB);
    chk("sb_strb", {28'd0, wr_q[0].wstrb}, 32'h2);
    chk("lb_val", wr_q[1].wdata, 32'hFFFF_FFFF);
    chk("lbu_val", wr_q[2].wdata, 32'h0000_00FF);
    chk("lh_val", wr_q[3].wdata, 32'hFFFF_80FF);
    chk("ld_wr_addr", wr_q[3].addr, 32'h40);

    // signed vs unsigned branch, jalr bit0 clearing and link value
    start(PROG_BRANCH, 0);
    run_writes("br_wr_cnt", 1, 400);
    chk("blt_taken", fetch_after(32'h08), 32'h10);
    chk("bltu_not_taken", fetch_after(32'h10), 32'h14);
    chk("jalr_target", fetch_after(32'h14), 32'h20);
    chk("jalr_link", wr_q[0].wdata, 32'h18);
    chk("br_trap", {31'd0, trap}, 32'd0);

    // traps: zero word, ecall, misaligned lw (no data request)
    start(PROG_ZERO, 0);
    run_trap("zero_trap", 20);
    check_quiet("zero_quiet");
    chk("zero_txns", log_q.size(), 1);

    start(PROG_ECALL, 0);
    run_trap("ecall_trap", 20);
    check_quiet("ecall_quiet");

    start(PROG_MISLW, 0);
    run_trap("mislw_trap", 20);
    check_quiet("mislw_quiet");
    chk("mislw_txns", log_q.size(), 1);

    // reset while a fetch of 0x8 is waiting
    start(PROG_LOOP, 20);
    for (int i = 0; i < 400 && !(mem_valid && mem_instr && mem_addr == 32'h8); i++) begin
      @(negedge clk);
      #1;
    end
    chk("rstmid_pending", {31'd0, mem_valid && mem_addr == 32'h8}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, mem_valid}, 32'd0);
    start(PROG_LOOP, 0);
    for (int i = 0; i < 20 && log_q.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rstmid_refetch", log_q.size() > 0 ? log_q[0].addr : 32'hFFFF_FFFF, 32'h0);
    chk("rstmid_trap", {31'd0, trap}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
